// File: rtl/vlane_mulshift_arb_pkg.sv
// Shared definitions for the vector-lane MUL/shift arbiter: mulshift op codes
// ({half,sat,op,unsign,dir}) and the arbitration FSM state encoding.
// No ports; imported by the arbiter top.
package vlane_mulshift_arb_pkg;

  localparam logic [4:0] MS_OP_SLL     = 5'd0;
  localparam logic [4:0] MS_OP_SRL     = 5'd1;
  localparam logic [4:0] MS_OP_SRA     = 5'd3;
  localparam logic [4:0] MS_OP_MULLOU  = 5'd4;
  localparam logic [4:0] MS_OP_MULLO   = 5'd6;
  localparam logic [4:0] MS_OP_SLLSATU = 5'd8;
  localparam logic [4:0] MS_OP_SLLSAT  = 5'd10;
  localparam logic [4:0] MS_OP_LMULU   = 5'd14;
  localparam logic [4:0] MS_OP_UMULU   = 5'd15;
  localparam logic [4:0] MS_OP_LMUL    = 5'd16;
  localparam logic [4:0] MS_OP_UMUL    = 5'd17;

  // Op code driven to the unit on cycles with no issue.
  localparam logic [4:0] MS_OP_IDLE    = 5'd0;

  typedef enum logic {
    ST_ARB  = 1'b0,  // round-robin among all requesters
    ST_LOCK = 1'b1   // burst in progress, only the locked requester may issue
  } arb_state_t;

endpackage

// File: rtl/vlane_rr_arb.sv
// Round-robin priority picker, purely combinational (0 cycles latency).
// Ports: req (request vector), rr_ptr (highest-priority index), lock_en/lock_id
// (restrict grant to one requester), grant_valid/grant (winner). No backpressure.
module vlane_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            lock_en,
  input  logic [IDW-1:0]  lock_id,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    if (lock_en) begin
      // A bubble from the locked requester simply yields no grant.
      grant_valid = req[lock_id];
      grant       = lock_id;
    end else begin
      // Scan starting at rr_ptr; the IDW-bit add wraps since NREQ is 2**IDW.
      for (int i = 0; i < NREQ; i++) begin
        idx = rr_ptr + IDW'(i);
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant       = idx;
        end
      end
    end
  end

endmodule

// File: rtl/vlane_mulshift_arb.sv
// Shares one mulshift unit among NREQ requesters: round-robin with burst lock,
// results tagged with requester ID and returned via a 2-entry FIFO (accept T -> rsp T+2).
// Ports: req_* (per-requester valid/ready/operands), ms_* (unit interface),
// rsp_* (valid/ready result stream). Issue stalls when FIFO + in-flight would exceed 2.
module vlane_mulshift_arb
  import vlane_mulshift_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*WIDTH-1:0]     req_opA,
  input  logic [NREQ*WIDTH-1:0]     req_opB,
  input  logic [NREQ*LOG2WIDTH-1:0] req_sa,
  input  logic [NREQ*5-1:0]         req_op,
  output logic [WIDTH-1:0]          ms_opA,
  output logic [WIDTH-1:0]          ms_opB,
  output logic [LOG2WIDTH-1:0]      ms_sa,
  output logic [4:0]                ms_op,
  output logic [3:1]                ms_en,
  input  logic [WIDTH-1:0]          ms_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [WIDTH-1:0]          rsp_result
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_q, lock_d;

  logic           grant_valid;
  logic [IDW-1:0] grant;
  logic           grant_last;

  logic           s1_valid;
  logic [IDW-1:0] s1_id;

  logic [IDW-1:0]   fifo_id  [2];
  logic [WIDTH-1:0] fifo_res [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;

  logic       push, pop, credit_ok, issue;
  logic [2:0] occ;

  vlane_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .lock_en     (state_q == ST_LOCK),
    .lock_id     (lock_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Occupancy counts the op inside the unit as already holding a FIFO slot,
  // so a result always has somewhere to land the cycle after capture.
  assign occ       = {1'b0, count} + {2'b00, s1_valid};
  assign pop       = rsp_valid & rsp_ready;
  assign push      = s1_valid;
  assign credit_ok = (occ < 3'd2) || (pop && (occ < 3'd3));
  // resetn gates issue so nothing is offered while reset is held.
  assign issue     = grant_valid & credit_ok & ~flush & resetn;

  assign req_ready  = issue ? (NREQ'(1) << grant) : '0;
  assign grant_last = req_last[grant];

  assign ms_opA = issue ? req_opA[grant*WIDTH +: WIDTH] : '0;
  assign ms_opB = issue ? req_opB[grant*WIDTH +: WIDTH] : '0;
  assign ms_sa  = issue ? req_sa[grant*LOG2WIDTH +: LOG2WIDTH] : '0;
  assign ms_op  = issue ? req_op[grant*5 +: 5] : MS_OP_IDLE;
  // Unit must keep clocking while s1 holds an op so its result is presented.
  assign ms_en  = {3{issue | s1_valid}};

  assign rsp_valid  = (count != 2'd0);
  assign rsp_id     = rsp_valid ? fifo_id[rd_ptr]  : '0;
  assign rsp_result = rsp_valid ? fifo_res[rd_ptr] : '0;

  // Arbitration FSM: next state
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      state_d = ST_ARB;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (issue) begin
            rr_ptr_d = grant + IDW'(1);
            if (!grant_last) begin
              lock_d  = grant;
              state_d = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (issue && grant_last) begin
            rr_ptr_d = lock_q + IDW'(1);
            state_d  = ST_ARB;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  // Arbitration FSM: state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
    end
  end

  // Pipeline and FIFO control; flush discards the op in the unit and all entries.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      s1_valid <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data-only storage; outputs are masked by rsp_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (issue) s1_id <= grant;
    if (push) begin
      fifo_id[wr_ptr]  <= s1_id;
      fifo_res[wr_ptr] <= ms_result;
    end
  end

endmodule

// File: tb/tb_vlane_mulshift_arb.sv
module tb_vlane_mulshift_arb;
  import vlane_mulshift_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 32;
  localparam int SW   = 5;

  logic             clk = 1'b0;
  logic             resetn, flush;
  logic [NREQ-1:0]  req_valid, req_ready, req_last;
  logic [NREQ*W-1:0]  req_opA, req_opB;
  logic [NREQ*SW-1:0] req_sa;
  logic [NREQ*5-1:0]  req_op;
  logic [W-1:0]     ms_opA, ms_opB;
  logic [SW-1:0]    ms_sa;
  logic [4:0]       ms_op;
  logic [3:1]       ms_en;
  logic [W-1:0]     ms_result = '0;
  logic             rsp_valid, rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vlane_mulshift_arb #(.NREQ(NREQ), .IDW(IDW), .WIDTH(W), .LOG2WIDTH(SW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_opA(req_opA), .req_opB(req_opB), .req_sa(req_sa), .req_op(req_op),
    .ms_opA(ms_opA), .ms_opB(ms_opB), .ms_sa(ms_sa), .ms_op(ms_op), .ms_en(ms_en),
    .ms_result(ms_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  // Behavioural stand-in for the shared mulshift unit (subset of ops used here).
  always @(posedge clk) begin
    if (ms_en[1]) begin
      case (ms_op)
        MS_OP_SLL:    ms_result <= ms_opA << ms_sa;
        MS_OP_SRL:    ms_result <= ms_opA >> ms_sa;
        MS_OP_SRA:    ms_result <= $signed(ms_opA) >>> ms_sa;
        MS_OP_MULLOU,
        MS_OP_MULLO:  ms_result <= ms_opA * ms_opB;
        default:      ms_result <= '0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic v, input logic l, input logic [4:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] sa);
    req_valid[i]        = v;
    req_last[i]         = l;
    req_op[i*5 +: 5]    = op;
    req_opA[i*W +: W]   = a;
    req_opB[i*W +: W]   = b;
    req_sa[i*SW +: SW]  = sa;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_last  = '0;
    req_opA   = '0;
    req_opB   = '0;
    req_sa    = '0;
    req_op    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_reqs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, MS_OP_MULLOU, 32'd3, 32'd3, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++;
    if (ms_en !== 3'b000) begin bad++; $display("FAIL reset_ms_en got=%b exp=000", ms_en); end
    total++;
    if (ms_op !== 5'd0) begin bad++; $display("FAIL reset_ms_op got=%0d exp=0", ms_op); end
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 32'd0) begin
      bad++; $display("FAIL reset_rsp got v=%b id=%0d r=%h exp v=0 id=0 r=0", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    @(negedge clk);
    clear_reqs();
    resetn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, MS_OP_MULLOU, 32'd7, 32'd9, 5'd0);
    #1;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    total++;
    if (ms_en !== 3'b111 || ms_op !== 5'd4 || ms_opA !== 32'd7 || ms_opB !== 32'd9) begin
      bad++; $display("FAIL single_drive got en=%b op=%0d a=%0d b=%0d exp en=111 op=4 a=7 b=9", ms_en, ms_op, ms_opA, ms_opB);
    end
    total++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_valid !== 1'b0 || ms_en !== 3'b111 || ms_op !== 5'd0 || ms_opA !== 32'd0) begin
      bad++; $display("FAIL single_t1 got v=%b en=%b op=%0d a=%0d exp v=0 en=111 op=0 a=0", rsp_valid, ms_en, ms_op, ms_opA);
    end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd63) begin
      bad++; $display("FAIL single_rsp got v=%b id=%0d r=%0d exp v=1 id=0 r=63", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b0 || ms_en !== 3'b000) begin
      bad++; $display("FAIL single_idle got v=%b en=%b exp v=0 en=000", rsp_valid, ms_en);
    end
    total++;
  endtask

  task automatic test_shift();
    @(negedge clk);
    set_req(2, 1'b1, 1'b1, MS_OP_SLL, 32'd1, 32'd0, 5'd4);
    #1;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL shift_ready0 got=%b exp=0100", req_ready); end
    total++;
    @(negedge clk);
    set_req(2, 1'b1, 1'b1, MS_OP_SRL, 32'h8000_0000, 32'd0, 5'd31);
    #1;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL shift_ready1 got=%b exp=0100", req_ready); end
    total++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd16) begin
      bad++; $display("FAIL shift_sll got v=%b id=%0d r=%h exp v=1 id=2 r=10", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd1) begin
      bad++; $display("FAIL shift_srl got v=%b id=%0d r=%h exp v=1 id=2 r=1", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL shift_drain got v=%b exp v=0", rsp_valid); end
    total++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy [5];
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, MS_OP_MULLOU, 32'(i*10 + 1), 32'd1, 5'd0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) clear_reqs();
      #1;
      if (k < 5) begin
        if (req_ready !== exp_rdy[k]) begin
          bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_rdy[k]);
        end
        total++;
      end
      if (k >= 2) begin
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'((k-2) % 4) || rsp_result !== 32'(((k-2) % 4)*10 + 1)) begin
          bad++; $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d r=%0d exp v=1 id=%0d r=%0d",
                          k, rsp_valid, rsp_id, rsp_result, (k-2) % 4, ((k-2) % 4)*10 + 1);
        end
        total++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_burst_lock();
    logic [3:0] exp_rdy [9];
    int ids[$];
    int res[$];
    int exp_id  [4];
    int exp_res [4];
    exp_rdy[0] = 4'b0010; exp_rdy[1] = 4'b0000; exp_rdy[2] = 4'b0010;
    exp_rdy[3] = 4'b0010; exp_rdy[4] = 4'b0001; exp_rdy[5] = 4'b0000;
    exp_rdy[6] = 4'b0000; exp_rdy[7] = 4'b0000; exp_rdy[8] = 4'b0000;
    exp_id[0] = 1; exp_id[1] = 1; exp_id[2] = 1; exp_id[3] = 0;
    exp_res[0] = 11; exp_res[1] = 12; exp_res[2] = 13; exp_res[3] = 50;
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      case (k)
        0: begin
          set_req(1, 1'b1, 1'b0, MS_OP_MULLOU, 32'd11, 32'd1, 5'd0);
          set_req(0, 1'b1, 1'b1, MS_OP_MULLOU, 32'd50, 32'd1, 5'd0);
        end
        1: req_valid[1] = 1'b0;
        2: set_req(1, 1'b1, 1'b0, MS_OP_MULLOU, 32'd12, 32'd1, 5'd0);
        3: set_req(1, 1'b1, 1'b1, MS_OP_MULLOU, 32'd13, 32'd1, 5'd0);
        4: req_valid[1] = 1'b0;
        5: req_valid[0] = 1'b0;
        default: ;
      endcase
      #1;
      if (req_ready !== exp_rdy[k]) begin
        bad++; $display("FAIL burst_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_rdy[k]);
      end
      total++;
      if (rsp_valid === 1'b1) begin
        ids.push_back(int'(rsp_id));
        res.push_back(int'(rsp_result));
      end
    end
    if (ids.size() != 4) begin
      bad++; $display("FAIL burst_count got=%0d exp=4", ids.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (ids[j] != exp_id[j] || res[j] != exp_res[j]) begin
          bad++; $display("FAIL burst_order idx=%0d got id=%0d r=%0d exp id=%0d r=%0d", j, ids[j], res[j], exp_id[j], exp_res[j]);
        end
        total++;
      end
    end
    total++;
    clear_reqs();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy [10];
    logic [2:0] exp_en  [10];
    logic       exp_v   [10];
    int         exp_id  [10];
    exp_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    exp_en  = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
    exp_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_id  = '{0, 0, 1, 1, 1, 1, 2, 3, 0, 0};
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      case (k)
        0: for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, MS_OP_MULLOU, 32'(100 + i), 32'd1, 5'd0);
        1: req_valid[1] = 1'b0;
        2: req_valid[2] = 1'b0;
        5: rsp_ready = 1'b1;
        6: req_valid[3] = 1'b0;
        7: req_valid[0] = 1'b0;
        default: ;
      endcase
      #1;
      if (req_ready !== exp_rdy[k] || ms_en !== exp_en[k]) begin
        bad++; $display("FAIL bp_issue cyc=%0d got rdy=%b en=%b exp rdy=%b en=%b", k, req_ready, ms_en, exp_rdy[k], exp_en[k]);
      end
      total++;
      if (k >= 2) begin
        if (rsp_valid !== exp_v[k] ||
            (exp_v[k] && (rsp_id !== IDW'(exp_id[k]) || rsp_result !== 32'(100 + exp_id[k])))) begin
          bad++; $display("FAIL bp_rsp cyc=%0d got v=%b id=%0d r=%0d exp v=%b id=%0d r=%0d",
                          k, rsp_valid, rsp_id, rsp_result, exp_v[k], exp_id[k], 100 + exp_id[k]);
        end
        total++;
      end
    end
    clear_reqs();
  endtask

  task automatic test_flush();
    rsp_ready = 1'b0;
    // Flush with one entry buffered and one op inside the unit.
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, MS_OP_MULLOU, 32'd5, 32'd1, 5'd0);
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, MS_OP_MULLOU, 32'd6, 32'd1, 5'd0);
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, MS_OP_MULLOU, 32'd7, 32'd1, 5'd0);
    rsp_ready = 1'b1;
    flush     = 1'b1;
    #1;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
    total++;
    @(negedge clk);
    flush = 1'b0;
    clear_reqs();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL flush1_stale cyc=%0d got v=%b id=%0d exp v=0", k, rsp_valid, rsp_id);
      end
      total++;
    end
    // Flush with the FIFO full.
    rsp_ready = 1'b0;
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, MS_OP_MULLOU, 32'd8, 32'd1, 5'd0);
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, MS_OP_MULLOU, 32'd9, 32'd1, 5'd0);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd8) begin
      bad++; $display("FAIL flush2_full got v=%b id=%0d r=%0d exp v=1 id=1 r=8", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    flush = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    rsp_ready = 1'b1;
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush2_empty got v=%b exp v=0", rsp_valid); end
    total++;
    // rr_ptr kept at 2 across flush: req3 wins; only its result may appear.
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, MS_OP_MULLOU, 32'd77, 32'd1, 5'd0);
    #1;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL flush_resume_ready got=%b exp=1000", req_ready); end
    total++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_resume_early got v=%b exp v=0", rsp_valid); end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'd77) begin
      bad++; $display("FAIL flush_resume_rsp got v=%b id=%0d r=%0d exp v=1 id=3 r=77", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_resume_drain got v=%b exp v=0", rsp_valid); end
    total++;
  endtask

  task automatic test_reset_midburst();
    rsp_ready = 1'b1;
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, MS_OP_MULLOU, 32'd21, 32'd1, 5'd0);
    #1;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL rst_burst_ready got=%b exp=0100", req_ready); end
    total++;
    @(negedge clk);
    resetn = 1'b0;
    set_req(2, 1'b1, 1'b0, MS_OP_MULLOU, 32'd22, 32'd1, 5'd0);
    #1;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_hold_ready got=%b exp=0000", req_ready); end
    total++;
    // rr_ptr=0 and no lock: of {0,3} requester 0 must win.
    @(negedge clk);
    resetn = 1'b1;
    clear_reqs();
    set_req(0, 1'b1, 1'b1, MS_OP_MULLOU, 32'd30, 32'd1, 5'd0);
    set_req(3, 1'b1, 1'b1, MS_OP_MULLOU, 32'd33, 32'd1, 5'd0);
    #1;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_after_ready got=%b exp=0001", req_ready); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_after_rsp got v=%b exp v=0", rsp_valid); end
    total++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_inflight got v=%b exp v=0", rsp_valid); end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd30) begin
      bad++; $display("FAIL rst_new_rsp got v=%b id=%0d r=%0d exp v=1 id=0 r=30", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_drain got v=%b exp v=0", rsp_valid); end
    total++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_flush();
    test_reset_midburst();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
